// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
//   Shared definitions for the dual-port RAM access controller.
//   - DW / AW     : default data / address widths (16 x 8 RAM)
//   - CNT_W/MAX   : width and saturation value of the collision counter
//   - req_t       : one requester's command (we, addr, wdata)
//   - prio_e      : round-robin priority state (favour A / favour B)
//   - sat_inc     : saturating increment for the collision counter
// -----------------------------------------------------------------------------
package dpram_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter. Without a conflict every request is granted.
//   On a conflict exactly one requester is granted according to the priority
//   flop, which then moves to the loser so the loser wins the next conflict.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   req[1:0]      : request vector (bit 0 = A, bit 1 = B)
//   conflict      : both requesters collide this cycle
//   gnt[1:0]      : combinational grant vector
// -----------------------------------------------------------------------------
import dpram_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       conflict,
  output logic [1:0] gnt
);

  prio_e r_prio;

  // The winner is always the favoured side, so toggling points at the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= PRIO_A;
    end else if (conflict) begin
      r_prio <= (r_prio == PRIO_A) ? PRIO_B : PRIO_A;
    end
  end

  always_comb begin
    gnt = req;
    if (conflict) begin
      gnt = (r_prio == PRIO_A) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_port_arbiter
//   Access controller in front of a 16x8 dual-port RAM. Requester A drives RAM
//   port A, requester B drives RAM port B. Same-address collisions involving a
//   write are resolved by round-robin; read/read never collides. Read data is
//   returned with a registered rvalid strobe; collision cycles are counted.
//
//   Optional build macro DPRAM_ARB_FWD_EN: a write/read collision is not
//   stalled; the write proceeds and the reader receives the write data from a
//   per-port forwarding register one cycle later. Write/write still arbitrates.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   a_/b_req, _we, _addr, _wdata     : requester commands (held until granted)
//   a_/b_gnt                         : combinational grants
//   a_/b_rvalid, a_/b_rdata          : read return
//   ram_we_*, ram_re_*, ram_addr_*,
//   ram_din_*, ram_dout_*            : RAM port controls and data
//   conflict_cnt                     : saturating collision-cycle count
// -----------------------------------------------------------------------------
import dpram_pkg::*;

module dpram_port_arbiter #(
  parameter int unsigned DW = dpram_pkg::DW,
  parameter int unsigned AW = dpram_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          ram_we_a,
  output logic          ram_we_b,
  output logic          ram_re_a,
  output logic          ram_re_b,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_din_a,
  output logic [DW-1:0] ram_din_b,
  input  logic [DW-1:0] ram_dout_a,
  input  logic [DW-1:0] ram_dout_b,
  output logic [7:0]    conflict_cnt
);

  req_t             w_a_cmd;
  req_t             w_b_cmd;
  logic             w_same_addr;
  logic             w_conflict;
  logic             w_arb_conflict;
  logic             w_fwd_to_a;
  logic             w_fwd_to_b;
  logic [1:0]       w_arb_gnt;
  logic             w_a_acc;
  logic             w_b_acc;
  logic             r_a_rvalid;
  logic             r_b_rvalid;
  logic [CNT_W-1:0] r_conflict_cnt;

  assign w_a_cmd = '{we: a_we, addr: a_addr, wdata: a_wdata};
  assign w_b_cmd = '{we: b_we, addr: b_addr, wdata: b_wdata};

  assign w_same_addr = a_req & b_req & (w_a_cmd.addr == w_b_cmd.addr);
  assign w_conflict  = w_same_addr & (w_a_cmd.we | w_b_cmd.we);

`ifdef DPRAM_ARB_FWD_EN
  // Mixed write/read collisions bypass arbitration: only write/write stalls.
  assign w_fwd_to_b     = w_same_addr & w_a_cmd.we & ~w_b_cmd.we;
  assign w_fwd_to_a     = w_same_addr & w_b_cmd.we & ~w_a_cmd.we;
  assign w_arb_conflict = w_conflict & ~(w_fwd_to_a | w_fwd_to_b);
`else
  assign w_fwd_to_a     = 1'b0;
  assign w_fwd_to_b     = 1'b0;
  assign w_arb_conflict = w_conflict;
`endif

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({b_req, a_req}),
    .conflict (w_arb_conflict),
    .gnt      (w_arb_gnt)
  );

  // Grants (and therefore every RAM strobe) are held low during reset.
  assign a_gnt   = w_arb_gnt[0] & rst_n;
  assign b_gnt   = w_arb_gnt[1] & rst_n;
  assign w_a_acc = a_req & a_gnt;
  assign w_b_acc = b_req & b_gnt;

  assign ram_we_a   = w_a_acc & w_a_cmd.we;
  assign ram_we_b   = w_b_acc & w_b_cmd.we;
  assign ram_re_a   = w_a_acc & ~w_a_cmd.we & ~w_fwd_to_a;
  assign ram_re_b   = w_b_acc & ~w_b_cmd.we & ~w_fwd_to_b;
  assign ram_addr_a = w_a_cmd.addr;
  assign ram_addr_b = w_b_cmd.addr;
  assign ram_din_a  = w_a_cmd.wdata;
  assign ram_din_b  = w_b_cmd.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= ram_re_a | (w_fwd_to_a & w_a_acc);
      r_b_rvalid <= ram_re_b | (w_fwd_to_b & w_b_acc);
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_arb_conflict) begin
      r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end
  end

  assign conflict_cnt = r_conflict_cnt;

`ifdef DPRAM_ARB_FWD_EN
  logic          r_a_fwd_sel;
  logic          r_b_fwd_sel;
  logic [DW-1:0] r_a_fwd_data;
  logic [DW-1:0] r_b_fwd_data;

  // The select flag lives only for the cycle its rvalid is high, so a later
  // RAM read on the same port returns ram_dout again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_fwd_sel  <= 1'b0;
      r_b_fwd_sel  <= 1'b0;
      r_a_fwd_data <= '0;
      r_b_fwd_data <= '0;
    end else begin
      r_a_fwd_sel <= w_fwd_to_a & w_a_acc;
      r_b_fwd_sel <= w_fwd_to_b & w_b_acc;
      if (w_fwd_to_a) begin
        r_a_fwd_data <= w_b_cmd.wdata;
      end
      if (w_fwd_to_b) begin
        r_b_fwd_data <= w_a_cmd.wdata;
      end
    end
  end

  assign a_rdata = r_a_fwd_sel ? r_a_fwd_data : ram_dout_a;
  assign b_rdata = r_b_fwd_sel ? r_b_fwd_data : ram_dout_b;
`else
  assign a_rdata = ram_dout_a;
  assign b_rdata = ram_dout_b;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_port_arbiter
//   Directed self-checking bench for dpram_port_arbiter with a behavioural
//   16x8 dual-port RAM (registered read data) attached to the RAM ports.
// -----------------------------------------------------------------------------
module tb_dpram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_we_a, ram_we_b, ram_re_a, ram_re_b;
  logic [3:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_din_a, ram_din_b;
  logic [7:0] ram_dout_a, ram_dout_b;
  logic [7:0] conflict_cnt;

  int n_checks;
  int n_errors;

  dpram_port_arbiter #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_re_a(ram_re_a), .ram_re_b(ram_re_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    if (ram_re_a) ram_dout_a <= mem[ram_addr_a];
    if (ram_re_b) ram_dout_b <= mem[ram_addr_b];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
  endtask

  task automatic idle_b();
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic drive_a(input logic we, input logic [3:0] addr, input logic [7:0] d);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
  endtask

  task automatic drive_b(input logic we, input logic [3:0] addr, input logic [7:0] d);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
  endtask

  task automatic do_reset();
    idle_a(); idle_b();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(1'b1, 4'h2, 8'hAA);
    drive_b(1'b1, 4'h2, 8'hBB);
    #2;
    n_checks++; if (a_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_a_gnt: got %b exp 0", a_gnt); end
    n_checks++; if (b_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_b_gnt: got %b exp 0", b_gnt); end
    n_checks++; if ({ram_we_a, ram_we_b, ram_re_a, ram_re_b} !== 4'b0000) begin
      n_errors++; $display("FAIL rst_strobes: got %b exp 0000", {ram_we_a, ram_we_b, ram_re_a, ram_re_b}); end
    n_checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_errors++; $display("FAIL rst_rvalid: got %b exp 00", {a_rvalid, b_rvalid}); end
    n_checks++; if (conflict_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_cnt: got %0d exp 0", conflict_cnt); end
    tick();
    idle_a(); idle_b();
    rst_n = 1'b1;
  endtask

  task automatic test_uncontended();
    tick();
    drive_a(1'b1, 4'hA, 8'h01);
    drive_b(1'b1, 4'hF, 8'h02);
    #2;
    n_checks++; if ({a_gnt, b_gnt} !== 2'b11) begin n_errors++; $display("FAIL unc_wr_gnt: got %b exp 11", {a_gnt, b_gnt}); end
    n_checks++; if ({ram_we_a, ram_we_b} !== 2'b11) begin n_errors++; $display("FAIL unc_wr_we: got %b exp 11", {ram_we_a, ram_we_b}); end
    tick();
    drive_a(1'b0, 4'hA, 8'h00);
    drive_b(1'b0, 4'hF, 8'h00);
    #2;
    n_checks++; if ({ram_re_a, ram_re_b} !== 2'b11) begin n_errors++; $display("FAIL unc_rd_re: got %b exp 11", {ram_re_a, ram_re_b}); end
    n_checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_errors++; $display("FAIL unc_rvalid_early: got %b exp 00", {a_rvalid, b_rvalid}); end
    tick();
    idle_a(); idle_b();
    n_checks++; if ({a_rvalid, b_rvalid} !== 2'b11) begin n_errors++; $display("FAIL unc_rvalid: got %b exp 11", {a_rvalid, b_rvalid}); end
    n_checks++; if (a_rdata !== 8'h01) begin n_errors++; $display("FAIL unc_a_rdata: got %h exp 01", a_rdata); end
    n_checks++; if (b_rdata !== 8'h02) begin n_errors++; $display("FAIL unc_b_rdata: got %h exp 02", b_rdata); end
    tick();
    n_checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_errors++; $display("FAIL unc_rvalid_drop: got %b exp 00", {a_rvalid, b_rvalid}); end
  endtask

  task automatic test_ww_collision();
    drive_a(1'b1, 4'hF, 8'h11);
    drive_b(1'b1, 4'hF, 8'h22);
    #2;
    n_checks++; if ({a_gnt, b_gnt} !== 2'b10) begin n_errors++; $display("FAIL ww_cyc0_gnt: got %b exp 10", {a_gnt, b_gnt}); end
    tick();
    idle_a();
    #2;
    n_checks++; if ({a_gnt, b_gnt} !== 2'b01) begin n_errors++; $display("FAIL ww_cyc1_gnt: got %b exp 01", {a_gnt, b_gnt}); end
    n_checks++; if (conflict_cnt !== 8'd1) begin n_errors++; $display("FAIL ww_cnt_cyc1: got %0d exp 1", conflict_cnt); end
    tick();
    drive_b(1'b0, 4'hF, 8'h00);
    tick();
    idle_b();
    n_checks++; if (b_rvalid !== 1'b1) begin n_errors++; $display("FAIL ww_b_rvalid: got %b exp 1", b_rvalid); end
    n_checks++; if (b_rdata !== 8'h22) begin n_errors++; $display("FAIL ww_ram_final: got %h exp 22", b_rdata); end
    n_checks++; if (conflict_cnt !== 8'd1) begin n_errors++; $display("FAIL ww_cnt: got %0d exp 1", conflict_cnt); end
  endtask

  task automatic test_fairness();
    logic ea;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      drive_a(1'b1, 4'h3, 8'h30 + 8'(i));
      drive_b(1'b1, 4'h3, 8'h40 + 8'(i));
      #2;
      ea = (i % 2 == 0);
      n_checks++; if ({a_gnt, b_gnt} !== {ea, ~ea}) begin
        n_errors++; $display("FAIL fair_gnt_%0d: got %b exp %b", i, {a_gnt, b_gnt}, {ea, ~ea}); end
    end
    tick();
    idle_b();
    drive_a(1'b0, 4'h3, 8'h00);
    n_checks++; if (conflict_cnt !== 8'd6) begin n_errors++; $display("FAIL fair_cnt: got %0d exp 6", conflict_cnt); end
    tick();
    idle_a();
    n_checks++; if (a_rdata !== 8'h45) begin n_errors++; $display("FAIL fair_ram_final: got %h exp 45", a_rdata); end
  endtask

  task automatic test_readread();
    tick();
    drive_a(1'b1, 4'h5, 8'h5A);
    tick();
    drive_a(1'b0, 4'h5, 8'h00);
    drive_b(1'b0, 4'h5, 8'h00);
    #2;
    n_checks++; if ({a_gnt, b_gnt} !== 2'b11) begin n_errors++; $display("FAIL rr_gnt: got %b exp 11", {a_gnt, b_gnt}); end
    tick();
    idle_a(); idle_b();
    n_checks++; if ({a_rvalid, b_rvalid} !== 2'b11) begin n_errors++; $display("FAIL rr_rvalid: got %b exp 11", {a_rvalid, b_rvalid}); end
    n_checks++; if ({a_rdata, b_rdata} !== 16'h5A5A) begin n_errors++; $display("FAIL rr_rdata: got %h exp 5a5a", {a_rdata, b_rdata}); end
    n_checks++; if (conflict_cnt !== 8'd6) begin n_errors++; $display("FAIL rr_cnt: got %0d exp 6", conflict_cnt); end
  endtask

  task automatic test_forward();
    tick();
    drive_a(1'b1, 4'h4, 8'h77);
    drive_b(1'b0, 4'h4, 8'h00);
    #2;
    n_checks++; if (ram_re_b !== 1'b0) begin n_errors++; $display("FAIL fwd_re_b_cyc0: got %b exp 0", ram_re_b); end
    n_checks++; if (ram_we_a !== 1'b1) begin n_errors++; $display("FAIL fwd_we_a: got %b exp 1", ram_we_a); end
`ifdef DPRAM_ARB_FWD_EN
    n_checks++; if ({a_gnt, b_gnt} !== 2'b11) begin n_errors++; $display("FAIL fwd_gnt: got %b exp 11", {a_gnt, b_gnt}); end
    tick();
    idle_a(); idle_b();
    n_checks++; if (b_rvalid !== 1'b1) begin n_errors++; $display("FAIL fwd_b_rvalid: got %b exp 1", b_rvalid); end
    n_checks++; if (b_rdata !== 8'h77) begin n_errors++; $display("FAIL fwd_b_rdata: got %h exp 77", b_rdata); end
    n_checks++; if (conflict_cnt !== 8'd6) begin n_errors++; $display("FAIL fwd_cnt: got %0d exp 6", conflict_cnt); end
`else
    n_checks++; if ({a_gnt, b_gnt} !== 2'b10) begin n_errors++; $display("FAIL wr_stall_gnt: got %b exp 10", {a_gnt, b_gnt}); end
    tick();
    idle_a();
    #2;
    n_checks++; if ({b_gnt, ram_re_b} !== 2'b11) begin n_errors++; $display("FAIL wr_stall_b_late: got %b exp 11", {b_gnt, ram_re_b}); end
    tick();
    idle_b();
    n_checks++; if (b_rvalid !== 1'b1) begin n_errors++; $display("FAIL wr_stall_rvalid: got %b exp 1", b_rvalid); end
    n_checks++; if (b_rdata !== 8'h77) begin n_errors++; $display("FAIL wr_stall_rdata: got %h exp 77", b_rdata); end
    n_checks++; if (conflict_cnt !== 8'd7) begin n_errors++; $display("FAIL wr_stall_cnt: got %0d exp 7", conflict_cnt); end
`endif
    tick();
    n_checks++; if (b_rvalid !== 1'b0) begin n_errors++; $display("FAIL fwd_rvalid_drop: got %b exp 0", b_rvalid); end
  endtask

  task automatic test_reset_mid();
    drive_a(1'b0, 4'h4, 8'h00);
    tick();
    idle_a();
    n_checks++; if (a_rvalid !== 1'b1) begin n_errors++; $display("FAIL rm_rvalid_pre: got %b exp 1", a_rvalid); end
    drive_a(1'b1, 4'h9, 8'h91);
    drive_b(1'b1, 4'h9, 8'h92);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_rvalid !== 1'b0) begin n_errors++; $display("FAIL rm_rvalid_async: got %b exp 0", a_rvalid); end
    n_checks++; if ({a_gnt, b_gnt} !== 2'b00) begin n_errors++; $display("FAIL rm_gnt: got %b exp 00", {a_gnt, b_gnt}); end
    n_checks++; if ({ram_we_a, ram_we_b} !== 2'b00) begin n_errors++; $display("FAIL rm_we: got %b exp 00", {ram_we_a, ram_we_b}); end
    n_checks++; if (conflict_cnt !== 8'd0) begin n_errors++; $display("FAIL rm_cnt: got %0d exp 0", conflict_cnt); end
    tick();
    rst_n = 1'b1;
    #2;
    n_checks++; if ({a_gnt, b_gnt} !== 2'b10) begin n_errors++; $display("FAIL rm_first_prio: got %b exp 10", {a_gnt, b_gnt}); end
    tick();
    idle_a();
    #2;
    n_checks++; if (b_gnt !== 1'b1) begin n_errors++; $display("FAIL rm_b_next: got %b exp 1", b_gnt); end
    n_checks++; if (conflict_cnt !== 8'd1) begin n_errors++; $display("FAIL rm_cnt_after: got %0d exp 1", conflict_cnt); end
    tick();
    idle_b();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_a(); idle_b();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_uncontended();
    test_ww_collision();
    test_fairness();
    test_readread();
    test_forward();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
